// File: rtl/si5340_cfg_sequencer.sv
// Si5340 configuration sequencer: walks the config ROM and feeds page/register writes to the I2C byte master.
// Optional build macro SI5340_PREAMBLE_DELAY_EN adds a settle delay after the preamble words.
module si5340_cfg_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h74,
    parameter int         MEM_WIDTH      = 24,
    parameter int         WORD_NUMBER    = 326,
    parameter int         ADDR_WIDTH     = 9,
    parameter int         MAX_RETRY      = 3,
    parameter int         CLK_FREQ       = 125_000_000,
    parameter int         PREAMBLE_WORDS = 3,
    parameter int         DELAY_MS       = 300
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [MEM_WIDTH-1:0]  mem_data_i,
    output logic                  cmd_start_o,
    output logic                  cmd_stop_o,
    output logic                  cmd_write_o,
    output logic                  cmd_read_o,
    output logic                  ack_in_o,
    output logic [7:0]            din_o,
    input  logic                  cmd_ack_i,
    input  logic                  ack_out_i,
    input  logic                  al_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH-1:0] word_idx_o
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORD_NUMBER - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_PAGE,
        ST_WRITE,
        ST_NACK_STOP,
        ST_NEXT,
        ST_DONE,
        ST_ERR
`ifdef SI5340_PREAMBLE_DELAY_EN
        , ST_DELAY
`endif
    } state_t;

    state_t                state, state_n;
    logic [1:0]            byte_cnt, byte_cnt_n;
    logic [RETRY_W-1:0]    retry_cnt, retry_cnt_n;
    logic [ADDR_WIDTH-1:0] word_idx, word_idx_n;
    logic [7:0]            page_cache, page_cache_n;
    logic                  page_valid, page_valid_n;
    logic [23:0]           cur_word, cur_word_n;
    logic                  in_page, in_page_n;
    logic                  cmd_active, cmd_active_n;
    logic                  cmd_start, cmd_start_n;
    logic                  cmd_stop, cmd_stop_n;
    logic                  cmd_write, cmd_write_n;
    logic [7:0]            din, din_n;
    logic                  done, done_n;
    logic                  error, error_n;
    logic [7:0]            tx_byte;
    logic                  fail;
    state_t                after_write;

`ifdef SI5340_PREAMBLE_DELAY_EN
    localparam int DELAY_CYCLES = DELAY_MS * (CLK_FREQ / 1000);
    localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    logic [DLY_W-1:0] delay_cnt, delay_cnt_n;
`endif

    // Byte to send for the current position of a page or register transaction.
    always_comb begin
        tx_byte = {DEV_ADDR, 1'b0};
        case (byte_cnt)
            2'd0:    tx_byte = {DEV_ADDR, 1'b0};
            2'd1:    tx_byte = in_page ? 8'h01 : cur_word[15:8];
            default: tx_byte = in_page ? cur_word[23:16] : cur_word[7:0];
        endcase
    end

`ifdef SI5340_PREAMBLE_DELAY_EN
    assign after_write = (word_idx == ADDR_WIDTH'(PREAMBLE_WORDS - 1)) ? ST_DELAY : ST_NEXT;
`else
    assign after_write = ST_NEXT;
`endif

    // Next-state logic; the retry budget is per word, so page failures and register failures share it.
    always_comb begin
        state_n      = state;
        byte_cnt_n   = byte_cnt;
        retry_cnt_n  = retry_cnt;
        word_idx_n   = word_idx;
        page_cache_n = page_cache;
        page_valid_n = page_valid;
        cur_word_n   = cur_word;
        in_page_n    = in_page;
        cmd_active_n = cmd_active;
        cmd_start_n  = cmd_start;
        cmd_stop_n   = cmd_stop;
        cmd_write_n  = cmd_write;
        din_n        = din;
        done_n       = done;
        error_n      = error;
        fail         = 1'b0;
`ifdef SI5340_PREAMBLE_DELAY_EN
        delay_cnt_n  = delay_cnt;
`endif

        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                state_n = ST_IDLE;
                if (start_i) begin
                    done_n       = 1'b0;
                    error_n      = 1'b0;
                    page_valid_n = 1'b0;
                    word_idx_n   = '0;
                    retry_cnt_n  = '0;
                    state_n      = ST_FETCH;
                end
            end

            ST_FETCH: state_n = ST_DECODE;

            ST_DECODE: begin
                cur_word_n = mem_data_i[23:0];
                byte_cnt_n = 2'd0;
                if (!page_valid || (mem_data_i[23:16] != page_cache)) begin
                    in_page_n = 1'b1;
                    state_n   = ST_PAGE;
                end else begin
                    in_page_n = 1'b0;
                    state_n   = ST_WRITE;
                end
            end

            ST_PAGE, ST_WRITE: begin
                if (al_i) begin
                    cmd_active_n = 1'b0;
                    cmd_start_n  = 1'b0;
                    cmd_stop_n   = 1'b0;
                    cmd_write_n  = 1'b0;
                    din_n        = 8'h00;
                    fail         = 1'b1;
                end else if (!cmd_active) begin
                    cmd_active_n = 1'b1;
                    cmd_start_n  = (byte_cnt == 2'd0);
                    cmd_stop_n   = (byte_cnt == 2'd2);
                    cmd_write_n  = 1'b1;
                    din_n        = tx_byte;
                end else if (cmd_ack_i) begin
                    cmd_active_n = 1'b0;
                    cmd_start_n  = 1'b0;
                    cmd_stop_n   = 1'b0;
                    cmd_write_n  = 1'b0;
                    din_n        = 8'h00;
                    if (ack_out_i) begin
                        if (byte_cnt != 2'd2) begin
                            state_n = ST_NACK_STOP;
                        end else begin
                            fail = 1'b1;
                        end
                    end else if (byte_cnt == 2'd2) begin
                        byte_cnt_n = 2'd0;
                        if (in_page) begin
                            page_cache_n = cur_word[23:16];
                            page_valid_n = 1'b1;
                            in_page_n    = 1'b0;
                            state_n      = ST_WRITE;
                        end else begin
                            retry_cnt_n = '0;
                            state_n     = after_write;
`ifdef SI5340_PREAMBLE_DELAY_EN
                            delay_cnt_n = '0;
`endif
                        end
                    end else begin
                        byte_cnt_n = byte_cnt + 2'd1;
                    end
                end
            end

            // Release the bus after a mid-transaction NACK before retrying.
            ST_NACK_STOP: begin
                if (al_i || (cmd_active && cmd_ack_i)) begin
                    cmd_active_n = 1'b0;
                    cmd_start_n  = 1'b0;
                    cmd_stop_n   = 1'b0;
                    cmd_write_n  = 1'b0;
                    din_n        = 8'h00;
                    fail         = 1'b1;
                end else if (!cmd_active) begin
                    cmd_active_n = 1'b1;
                    cmd_start_n  = 1'b0;
                    cmd_stop_n   = 1'b1;
                    cmd_write_n  = 1'b0;
                    din_n        = 8'h00;
                end
            end

            ST_NEXT: begin
                if (word_idx == LAST_IDX) begin
                    done_n  = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    word_idx_n = word_idx + 1'b1;
                    state_n    = ST_FETCH;
                end
            end

`ifdef SI5340_PREAMBLE_DELAY_EN
            ST_DELAY: begin
                if (delay_cnt == DLY_W'(DELAY_CYCLES - 1)) begin
                    state_n = ST_NEXT;
                end else begin
                    delay_cnt_n = delay_cnt + 1'b1;
                end
            end
`endif

            default: state_n = ST_IDLE;
        endcase

        if (fail) begin
            byte_cnt_n = 2'd0;
            if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
                error_n = 1'b1;
                state_n = ST_ERR;
            end else begin
                retry_cnt_n = retry_cnt + 1'b1;
                state_n     = in_page ? ST_PAGE : ST_WRITE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state      <= ST_IDLE;
            byte_cnt   <= 2'd0;
            retry_cnt  <= '0;
            word_idx   <= '0;
            page_cache <= 8'h00;
            page_valid <= 1'b0;
            cur_word   <= 24'h0;
            in_page    <= 1'b0;
            cmd_active <= 1'b0;
            cmd_start  <= 1'b0;
            cmd_stop   <= 1'b0;
            cmd_write  <= 1'b0;
            din        <= 8'h00;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef SI5340_PREAMBLE_DELAY_EN
            delay_cnt  <= '0;
`endif
        end else begin
            state      <= state_n;
            byte_cnt   <= byte_cnt_n;
            retry_cnt  <= retry_cnt_n;
            word_idx   <= word_idx_n;
            page_cache <= page_cache_n;
            page_valid <= page_valid_n;
            cur_word   <= cur_word_n;
            in_page    <= in_page_n;
            cmd_active <= cmd_active_n;
            cmd_start  <= cmd_start_n;
            cmd_stop   <= cmd_stop_n;
            cmd_write  <= cmd_write_n;
            din        <= din_n;
            done       <= done_n;
            error      <= error_n;
`ifdef SI5340_PREAMBLE_DELAY_EN
            delay_cnt  <= delay_cnt_n;
`endif
        end
    end

    assign mem_addr_o  = word_idx;
    assign word_idx_o  = word_idx;
    assign cmd_start_o = cmd_start;
    assign cmd_stop_o  = cmd_stop;
    assign cmd_write_o = cmd_write;
    assign cmd_read_o  = 1'b0;
    assign ack_in_o    = 1'b0;
    assign din_o       = din;
    assign done_o      = done;
    assign error_o     = error;
    assign busy_o      = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERR);

endmodule

// File: tb/tb_si5340_cfg_sequencer.sv
// Testbench for si5340_cfg_sequencer: byte-master responder with scripted NACK/arbitration faults,
// directed scenario table and randomized ROM/fault runs checked against a transaction-level model.
module tb_si5340_cfg_sequencer;

    localparam int WORDS = 12;
    localparam int AW    = 4;
    localparam int MAXR  = 3;

    logic          clk_i = 1'b0;
    logic          arst_i;
    logic          start_i;
    logic [AW-1:0] mem_addr_o;
    logic [23:0]   mem_data_i;
    logic          cmd_start_o, cmd_stop_o, cmd_write_o, cmd_read_o, ack_in_o;
    logic [7:0]    din_o;
    logic          cmd_ack_i, ack_out_i, al_i;
    logic          busy_o, done_o, error_o;
    logic [AW-1:0] word_idx_o;

    si5340_cfg_sequencer #(
        .WORD_NUMBER (WORDS),
        .ADDR_WIDTH  (AW),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .start_i     (start_i),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i),
        .cmd_start_o (cmd_start_o),
        .cmd_stop_o  (cmd_stop_o),
        .cmd_write_o (cmd_write_o),
        .cmd_read_o  (cmd_read_o),
        .ack_in_o    (ack_in_o),
        .din_o       (din_o),
        .cmd_ack_i   (cmd_ack_i),
        .ack_out_i   (ack_out_i),
        .al_i        (al_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .word_idx_o  (word_idx_o)
    );

    always #5 clk_i = ~clk_i;

    logic [23:0] rom [0:15];
    assign mem_data_i = rom[mem_addr_o];

    int checks = 0;
    int errors = 0;

    // Responses per written byte: 0 = ACK, 1 = NACK, 2 = arbitration lost
    int          plan_q[$];
    int          plan_ref[$];
    logic [10:0] log_q[$];
    logic [10:0] exp_q[$];
    bit          exp_done, exp_err;
    int          exp_idx;

    typedef struct {
        int pos  [4];
        int code [4];
        bit exp_done;
        bit exp_err;
        int exp_idx;
        int exp_cmds;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input int p0, c0, p1, c1, p2, c2, p3, c3,
                                input bit d, input bit e, input int idx, input int cmds);
        vec_t v;
        v.pos[0] = p0; v.code[0] = c0;
        v.pos[1] = p1; v.code[1] = c1;
        v.pos[2] = p2; v.code[2] = c2;
        v.pos[3] = p3; v.code[3] = c3;
        v.exp_done = d;
        v.exp_err  = e;
        v.exp_idx  = idx;
        v.exp_cmds = cmds;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte-master stand-in: acks each command after a random latency and logs what was issued.
    initial begin : responder
        int          lat;
        int          code;
        bit          responded;
        logic [10:0] seen;
        lat = -1;
        responded = 1'b0;
        seen = '0;
        cmd_ack_i = 1'b0;
        ack_out_i = 1'b0;
        al_i = 1'b0;
        forever begin
            @(negedge clk_i);
            cmd_ack_i = 1'b0;
            ack_out_i = 1'b0;
            al_i = 1'b0;
            if (arst_i) begin
                lat = -1;
                responded = 1'b0;
            end else if (responded) begin
                responded = 1'b0;
                check_output("cmd_drop", {21'h0, cmd_start_o, cmd_stop_o, cmd_write_o, din_o}, 32'h0);
            end else if (cmd_write_o || cmd_stop_o) begin
                if (lat < 0) begin
                    lat = $urandom_range(0, 3);
                    seen = {cmd_start_o, cmd_stop_o, cmd_write_o, din_o};
                end else begin
                    check_output("cmd_hold", {21'h0, cmd_start_o, cmd_stop_o, cmd_write_o, din_o}, {21'h0, seen});
                end
                if (lat == 0) begin
                    log_q.push_back({cmd_start_o, cmd_stop_o, cmd_write_o, cmd_write_o ? din_o : 8'h00});
                    if (!cmd_write_o) begin
                        cmd_ack_i = 1'b1;
                    end else begin
                        code = 0;
                        if (plan_q.size() > 0) code = plan_q.pop_front();
                        if (code == 2) begin
                            al_i = 1'b1;
                        end else begin
                            cmd_ack_i = 1'b1;
                            ack_out_i = (code == 1);
                        end
                    end
                    responded = 1'b1;
                    lat = -1;
                end else begin
                    lat--;
                end
            end
        end
    end

    // Transaction-level model: every word is an optional page write then a register write,
    // each retried as a whole; one failure budget per word.
    task automatic run_model();
        int         p;
        int         code;
        int         retries;
        bit         pv;
        bit         ok;
        logic [7:0] pg;
        logic [7:0] b [3];
        exp_q.delete();
        p = 0;
        pv = 1'b0;
        pg = 8'h00;
        exp_done = 1'b0;
        exp_err = 1'b0;
        exp_idx = 0;
        for (int idx = 0; idx < WORDS; idx++) begin
            retries = 0;
            for (int t = 0; t < 2; t++) begin
                if (t == 1 || !pv || rom[idx][23:16] != pg) begin
                    b[0] = 8'hE8;
                    b[1] = (t == 0) ? 8'h01 : rom[idx][15:8];
                    b[2] = (t == 0) ? rom[idx][23:16] : rom[idx][7:0];
                    ok = 1'b0;
                    while (!ok) begin
                        ok = 1'b1;
                        for (int k = 0; k < 3 && ok; k++) begin
                            exp_q.push_back({k == 0, k == 2, 1'b1, b[k]});
                            code = (p < plan_ref.size()) ? plan_ref[p] : 0;
                            p++;
                            if (code != 0) begin
                                ok = 1'b0;
                                if (code == 1 && k != 2) exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h00});
                            end
                        end
                        if (!ok) begin
                            if (retries == MAXR) begin
                                exp_err = 1'b1;
                                exp_idx = idx;
                                return;
                            end
                            retries++;
                        end
                    end
                    if (t == 0) begin
                        pg = rom[idx][23:16];
                        pv = 1'b1;
                    end
                end
            end
        end
        exp_done = 1'b1;
        exp_idx = WORDS - 1;
    endtask

    task automatic load_fixed_rom();
        rom[0] = {8'h00, 8'h0B, 8'h24};
        rom[1] = {8'h00, 8'h0C, 8'h01};
        rom[2] = {8'h05, 8'h10, 8'h33};
        for (int i = 3; i < WORDS; i++) rom[i] = {8'h05, 8'(8'h20 + i), 8'(i * 7)};
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Runs one full load with the current ROM and plan, then compares against the model.
    task automatic apply_stimulus(input bit extra_start);
        int n;
        plan_ref = plan_q;
        run_model();
        log_q.delete();
        pulse_start();
        check_output("busy_after_start", {31'h0, busy_o}, 32'h1);
        n = 0;
        while (!(done_o || error_o) && n < 4000) begin
            @(negedge clk_i);
            n++;
            start_i = (extra_start && n == 30);
        end
        start_i = 1'b0;
        if (n >= 4000) check_output("completion_timeout", 32'h1, 32'h0);
        repeat (20) @(negedge clk_i);
        check_output("model_done", {31'h0, done_o}, {31'h0, exp_done});
        check_output("model_error", {31'h0, error_o}, {31'h0, exp_err});
        check_output("model_word_idx", {28'h0, word_idx_o}, exp_idx);
        check_output("busy_idle", {31'h0, busy_o}, 32'h0);
        check_output("cmd_count", log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            check_output($sformatf("cmd[%0d]", i), {21'h0, log_q[i]}, {21'h0, exp_q[i]});
    endtask

    initial begin
        logic [10:0] t1 [12];
        int n;
        logic [7:0] pg;
        int r;

        t1[0]  = {1'b1, 1'b0, 1'b1, 8'hE8};
        t1[1]  = {1'b0, 1'b0, 1'b1, 8'h01};
        t1[2]  = {1'b0, 1'b1, 1'b1, 8'h00};
        t1[3]  = {1'b1, 1'b0, 1'b1, 8'hE8};
        t1[4]  = {1'b0, 1'b0, 1'b1, 8'h0B};
        t1[5]  = {1'b0, 1'b1, 1'b1, 8'h24};
        t1[6]  = {1'b1, 1'b0, 1'b1, 8'hE8};
        t1[7]  = {1'b0, 1'b0, 1'b1, 8'h0C};
        t1[8]  = {1'b0, 1'b1, 1'b1, 8'h01};
        t1[9]  = {1'b1, 1'b0, 1'b1, 8'hE8};
        t1[10] = {1'b0, 1'b0, 1'b1, 8'h01};
        t1[11] = {1'b0, 1'b1, 1'b1, 8'h05};

        // {fault positions/codes, done, error, word_idx, command count} for the fixed ROM
        vecs[0] = mk(-1, 0, -1, 0, -1, 0, -1, 0, 1'b1, 1'b0, 11, 42);
        vecs[1] = mk(7, 1, 9, 1, -1, 0, -1, 0, 1'b1, 1'b0, 11, 48);
        vecs[2] = mk(18, 1, 19, 1, 20, 1, 21, 1, 1'b0, 1'b1, 4, 26);
        vecs[3] = mk(5, 2, -1, 0, -1, 0, -1, 0, 1'b1, 1'b0, 11, 45);
        vecs[4] = mk(9, 2, 10, 2, 11, 2, 15, 1, 1'b0, 1'b1, 2, 17);
        vecs[5] = mk(41, 1, -1, 0, -1, 0, -1, 0, 1'b1, 1'b0, 11, 45);

        arst_i = 1'b1;
        start_i = 1'b0;
        load_fixed_rom();
        repeat (3) @(negedge clk_i);
        check_output("reset_outputs",
                     {8'h0, mem_addr_o, cmd_start_o, cmd_stop_o, cmd_write_o, cmd_read_o, ack_in_o,
                      din_o, busy_o, done_o, error_o, word_idx_o}, 32'h0);
        arst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_output("idle_outputs", {29'h0, busy_o, done_o, error_o}, 32'h0);

        for (int v = 0; v < 6; v++) begin
            load_fixed_rom();
            plan_q.delete();
            for (int i = 0; i < 64; i++) plan_q.push_back(0);
            for (int k = 0; k < 4; k++)
                if (vecs[v].pos[k] >= 0) plan_q[vecs[v].pos[k]] = vecs[v].code[k];
            apply_stimulus(1'b0);
            check_output($sformatf("vec%0d_done", v), {31'h0, done_o}, {31'h0, vecs[v].exp_done});
            check_output($sformatf("vec%0d_error", v), {31'h0, error_o}, {31'h0, vecs[v].exp_err});
            check_output($sformatf("vec%0d_word_idx", v), {28'h0, word_idx_o}, vecs[v].exp_idx);
            check_output($sformatf("vec%0d_cmds", v), log_q.size(), vecs[v].exp_cmds);
            if (v == 0) begin
                for (int i = 0; i < 12; i++)
                    check_output($sformatf("seq[%0d]", i), {21'h0, log_q[i]}, {21'h0, t1[i]});
            end
        end

        // Asynchronous reset in the middle of word 10, then a clean reload from word 0.
        load_fixed_rom();
        plan_q.delete();
        log_q.delete();
        pulse_start();
        n = 0;
        while (!(word_idx_o == 4'd10 && cmd_write_o) && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 2000) check_output("word10_timeout", 32'h1, 32'h0);
        #2 arst_i = 1'b1;
        #1;
        check_output("arst_outputs",
                     {8'h0, mem_addr_o, cmd_start_o, cmd_stop_o, cmd_write_o, cmd_read_o, ack_in_o,
                      din_o, busy_o, done_o, error_o, word_idx_o}, 32'h0);
        repeat (2) @(negedge clk_i);
        arst_i = 1'b0;
        plan_q.delete();
        apply_stimulus(1'b0);
        for (int i = 0; i < 3; i++)
            check_output($sformatf("reload_page[%0d]", i), {21'h0, log_q[i]}, {21'h0, t1[i]});

        // Randomized ROM contents and fault plans; one run also pulses start while busy.
        for (int it = 0; it < 6; it++) begin
            pg = 8'($urandom);
            for (int i = 0; i < WORDS; i++) begin
                if ($urandom_range(0, 3) == 0) pg = 8'($urandom);
                rom[i] = {pg, 8'($urandom), 8'($urandom)};
            end
            plan_q.delete();
            for (int i = 0; i < 80; i++) begin
                r = $urandom_range(0, 99);
                plan_q.push_back((r < 8) ? 1 : ((r < 12) ? 2 : 0));
            end
            apply_stimulus(it == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

endmodule
